decode_stage: RTL and testbench

//  Decode stage directly downstream of the fetch stage. It holds the IF/ID pipeline

---
 rtl/decode_stage.sv | 108 ++++++++++
 tb/tb_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register with stall/flush, 16-entry register file
// with write-through bypass, read-address selection and immediate extension.
module decode_stage #(
  parameter int WIDTH       = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0]       PCPlus4F,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic [1:0]             RegSrcD,
  input  logic [1:0]             ImmSrcD,
  input  logic                   RegWriteW,
  input  logic [3:0]             WA3W,
  input  logic [WIDTH-1:0]       ResultW,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0]       PCPlus4D,
  output logic                   ValidD,
  output logic [3:0]             RA1D,
  output logic [3:0]             RA2D,
  output logic [3:0]             WA3D,
  output logic [WIDTH-1:0]       RD1D,
  output logic [WIDTH-1:0]       RD2D,
  output logic [WIDTH-1:0]       ExtImmD
);

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]       pcPlus4_q, pcPlus4_d;
  logic                   valid_q, valid_d;
  logic [WIDTH-1:0]       rf_q [16];
  logic [WIDTH-1:0]       pcPlus8;

  // Flush outranks stall so a redirect can squash a stalled instruction.
  always_comb begin
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    if (FlushD) begin
      instr_d   = '0;
      pcPlus4_d = '0;
      valid_d   = 1'b0;
    end else if (!StallD) begin
      instr_d   = InstrF;
      pcPlus4_d = PCPlus4F;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q   <= '0;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  // R15 is never written here; the PC is redirected in fetch instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (WA3W != 4'd15)) begin
      rf_q[WA3W] <= ResultW;
    end
  end

  assign InstrD   = instr_q;
  assign PCPlus4D = pcPlus4_q;
  assign ValidD   = valid_q;

  assign RA1D    = RegSrcD[0] ? 4'd15 : instr_q[19:16];
  assign RA2D    = RegSrcD[1] ? instr_q[15:12] : instr_q[3:0];
  assign WA3D    = instr_q[15:12];
  assign pcPlus8 = pcPlus4_q + WIDTH'(4);

  always_comb begin
    RD1D = rf_q[RA1D];
    if (RA1D == 4'd15)
      RD1D = pcPlus8;
    else if (RegWriteW && (WA3W == RA1D))
      RD1D = ResultW;
  end

  always_comb begin
    RD2D = rf_q[RA2D];
    if (RA2D == 4'd15)
      RD2D = pcPlus8;
    else if (RegWriteW && (WA3W == RA2D))
      RD2D = ResultW;
  end

  // Branch offsets are word-aligned, hence the two appended zero bits.
  always_comb begin
    ExtImmD = '0;
    case (ImmSrcD)
      2'b00:   ExtImmD = WIDTH'({56'd0, instr_q[7:0]});
      2'b01:   ExtImmD = WIDTH'({52'd0, instr_q[11:0]});
      2'b10:   ExtImmD = WIDTH'({{38{instr_q[23]}}, instr_q[23:0], 2'b00});
      default: ExtImmD = '0;
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the pipeline register and register file.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrF;
  logic [7:0]  PCPlus4F;
  logic        StallD, FlushD;
  logic [1:0]  RegSrcD, ImmSrcD;
  logic        RegWriteW;
  logic [3:0]  WA3W;
  logic [7:0]  ResultW;
  logic [31:0] InstrD;
  logic [7:0]  PCPlus4D;
  logic        ValidD;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic [7:0]  RD1D, RD2D, ExtImmD;

  int errors = 0;
  int checks = 0;

  int unsigned mRegs [16];
  int unsigned mInstr;
  int unsigned mPc4;
  int unsigned mValid;

  decode_stage #(.WIDTH(8), .INSTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .FlushD(FlushD), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
    .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD)
  );

  always #5 clk = ~clk;

  function automatic int unsigned expRa1();
    return RegSrcD[0] ? 15 : (mInstr >> 16) % 16;
  endfunction

  function automatic int unsigned expRa2();
    return RegSrcD[1] ? (mInstr >> 12) % 16 : mInstr % 16;
  endfunction

  function automatic int unsigned expRead(int unsigned addr);
    if (addr == 15) return (mPc4 + 4) % 256;
    if (RegWriteW && WA3W == addr) return ResultW;
    return mRegs[addr];
  endfunction

  function automatic int unsigned expImm();
    int v;
    case (ImmSrcD)
      2'd0: return mInstr % 256;
      2'd1: return (mInstr % 4096) % 256;
      2'd2: begin
        v = int'(mInstr % (1 << 24));
        if (v >= (1 << 23)) v = v - (1 << 24);
        return int'(v * 4) & 255;
      end
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = 0;
    mInstr = 0; mPc4 = 0; mValid = 0;
  endtask

  // One rising edge; the model consumes the same stable inputs the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (RegWriteW && WA3W != 15) mRegs[WA3W] = ResultW;
    if (FlushD) begin
      mInstr = 0; mPc4 = 0; mValid = 0;
    end else if (!StallD) begin
      mInstr = InstrF; mPc4 = PCPlus4F; mValid = 1;
    end
    #1;
  endtask

  task automatic idleInputs();
    InstrF = '0; PCPlus4F = '0; StallD = 0; FlushD = 0;
    RegSrcD = 2'b00; ImmSrcD = 2'b00; RegWriteW = 0; WA3W = '0; ResultW = '0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1;
    modelReset();
    #2;
    checks++;
    if (InstrD !== 32'h0 || ValidD !== 1'b0 || PCPlus4D !== 8'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got Instr=%h Valid=%b Pc4=%h, want 0/0/0", InstrD, ValidD, PCPlus4D);
    end
    @(negedge clk); reset = 0;
    InstrF = 32'hE0812003; PCPlus4F = 8'h44;
    RegWriteW = 1; WA3W = 4'd3; ResultW = 8'h77;
    tick();
    @(negedge clk); RegWriteW = 0;
    #2 reset = 1;
    #1;
    modelReset();
    checks++;
    if (InstrD !== 32'h0 || ValidD !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midrun: got Instr=%h Valid=%b, want 0/0", InstrD, ValidD);
    end
    @(negedge clk); reset = 0;
    InstrF = 32'h00030000;
    tick();
    checks++;
    if (RA1D !== 4'd3 || RD1D !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_r3_cleared: got RA1=%0d RD1=%h, want 3/00", RA1D, RD1D);
    end
  endtask

  task automatic test_normal_flow();
    @(negedge clk);
    idleInputs();
    InstrF = 32'hE0812003; PCPlus4F = 8'h10;
    tick();
    checks++;
    if (InstrD !== 32'hE0812003 || ValidD !== 1'b1 || PCPlus4D !== 8'h10) begin
      errors++;
      $display("[TB] FAIL normal_capture: got Instr=%h Valid=%b Pc4=%h, want E0812003/1/10", InstrD, ValidD, PCPlus4D);
    end
    checks++;
    if (RA1D !== 4'd1 || RA2D !== 4'd3 || WA3D !== 4'd2) begin
      errors++;
      $display("[TB] FAIL normal_addrs: got RA1=%0d RA2=%0d WA3=%0d, want 1/3/2", RA1D, RA2D, WA3D);
    end
    @(negedge clk); RegSrcD = 2'b10; #1;
    checks++;
    if (RA2D !== 4'd2) begin
      errors++;
      $display("[TB] FAIL ra2_regsrc: got %0d, want 2", RA2D);
    end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    idleInputs();
    StallD = 1; InstrF = 32'h12345678; PCPlus4F = 8'h99;
    tick(); tick();
    checks++;
    if (InstrD !== 32'hE0812003 || PCPlus4D !== 8'h10 || ValidD !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_hold: got Instr=%h Pc4=%h Valid=%b, want E0812003/10/1", InstrD, PCPlus4D, ValidD);
    end
    @(negedge clk); FlushD = 1;
    tick();
    checks++;
    if (InstrD !== 32'h0 || ValidD !== 1'b0 || PCPlus4D !== 8'h0) begin
      errors++;
      $display("[TB] FAIL flush_over_stall: got Instr=%h Valid=%b Pc4=%h, want 0/0/0", InstrD, ValidD, PCPlus4D);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idleInputs();
    InstrF = 32'hE0812003; PCPlus4F = 8'h20;
    tick();
    @(negedge clk);
    RegWriteW = 1; WA3W = 4'd1; ResultW = 8'h5A;
    #1;
    checks++;
    if (RD1D !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h, want 5a", RD1D);
    end
    checks++;
    if (RD2D !== expRead(3)) begin
      errors++;
      $display("[TB] FAIL bypass_other_port: got %h, want %h", RD2D, expRead(3));
    end
    StallD = 1;
    tick();
    @(negedge clk); RegWriteW = 0; #1;
    checks++;
    if (RD1D !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL bypass_written: got %h, want 5a", RD1D);
    end
  endtask

  task automatic test_r15();
    @(negedge clk);
    idleInputs();
    PCPlus4F = 8'hFE;
    tick();
    @(negedge clk); RegSrcD = 2'b01; #1;
    checks++;
    if (RA1D !== 4'd15 || RD1D !== 8'h02) begin
      errors++;
      $display("[TB] FAIL r15_wrap: got RA1=%0d RD1=%h, want 15/02", RA1D, RD1D);
    end
    @(negedge clk); StallD = 1; RegWriteW = 1; WA3W = 4'd15; ResultW = 8'h33; #1;
    checks++;
    if (RD1D !== 8'h02) begin
      errors++;
      $display("[TB] FAIL r15_no_bypass: got %h, want 02", RD1D);
    end
    tick();
    @(negedge clk); RegWriteW = 0; #1;
    checks++;
    if (RD1D !== 8'h02) begin
      errors++;
      $display("[TB] FAIL r15_no_write: got %h, want 02", RD1D);
    end
  endtask

  task automatic test_immediates();
    @(negedge clk);
    idleInputs();
    InstrF = 32'h00FFFFFE;
    tick();
    @(negedge clk); ImmSrcD = 2'b10; #1;
    checks++;
    if (ExtImmD !== 8'hF8) begin
      errors++;
      $display("[TB] FAIL imm_branch: got %h, want f8", ExtImmD);
    end
    @(negedge clk); InstrF = 32'h000003A7; ImmSrcD = 2'b00;
    tick();
    @(negedge clk); ImmSrcD = 2'b01; #1;
    checks++;
    if (ExtImmD !== 8'hA7) begin
      errors++;
      $display("[TB] FAIL imm_12bit: got %h, want a7", ExtImmD);
    end
    @(negedge clk); ImmSrcD = 2'b11; #1;
    checks++;
    if (ExtImmD !== 8'h00) begin
      errors++;
      $display("[TB] FAIL imm_zero_sel: got %h, want 00", ExtImmD);
    end
  endtask

  // Random traffic: check combinational outputs before each edge against the model.
  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      InstrF    = $urandom;
      PCPlus4F  = 8'($urandom);
      StallD    = ($urandom_range(0, 5) == 0);
      FlushD    = ($urandom_range(0, 9) == 0);
      RegSrcD   = 2'($urandom);
      ImmSrcD   = 2'($urandom);
      RegWriteW = $urandom_range(0, 1) == 1;
      WA3W      = 4'($urandom);
      ResultW   = 8'($urandom);
      #1;
      checks++;
      if (InstrD !== mInstr || PCPlus4D !== 8'(mPc4) || ValidD !== 1'(mValid)) begin
        errors++;
        $display("[TB] FAIL rand_pipe[%0d]: got %h/%h/%b, want %h/%h/%0d", n, InstrD, PCPlus4D, ValidD, mInstr, mPc4, mValid);
      end
      checks++;
      if (RA1D !== 4'(expRa1()) || RA2D !== 4'(expRa2()) || WA3D !== 4'((mInstr >> 12) % 16)) begin
        errors++;
        $display("[TB] FAIL rand_addr[%0d]: got %0d/%0d/%0d, want %0d/%0d/%0d", n, RA1D, RA2D, WA3D, expRa1(), expRa2(), (mInstr >> 12) % 16);
      end
      checks++;
      if (RD1D !== 8'(expRead(expRa1())) || RD2D !== 8'(expRead(expRa2()))) begin
        errors++;
        $display("[TB] FAIL rand_read[%0d]: got %h/%h, want %h/%h", n, RD1D, RD2D, expRead(expRa1()), expRead(expRa2()));
      end
      checks++;
      if (ExtImmD !== 8'(expImm())) begin
        errors++;
        $display("[TB] FAIL rand_imm[%0d]: got %h, want %h (sel %0d)", n, ExtImmD, expImm(), ImmSrcD);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_normal_flow();
    test_stall_flush();
    test_bypass();
    test_r15();
    test_immediates();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
